// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART definitions: transmitter FSM states, data width and
//          baud divider helper. UART_TX_PARITY_EN adds the PARITY state.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } uart_tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
    } uart_tx_state_t;
`endif

    // Clock cycles per bit; truncating division.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_fifo
// Brief  : Synchronous FIFO with push/pop/full/empty/count; head visible
//          combinationally on pop_data.
// Rev    : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped, so a same-cycle pop then frees one slot.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_ctrl
// Brief  : Buffered UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN).
// Rev    : 1.0
// ============================================================================
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    output logic                 busy
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int CNT_W = $clog2(DIV);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    uart_tx_state_t       state;
    uart_tx_state_t       state_next;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_idx_next;
    logic [DATA_BITS-1:0] shreg;
    logic                 line_next;
    logic                 bit_done;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FCW-1:0]       fifo_count;
    logic [DATA_BITS-1:0] fifo_head;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign busy     = (state != ST_IDLE) || (fifo_count != '0);
    assign bit_done = (baud_cnt == CNT_LAST);

    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        fifo_pop     = 1'b0;
        line_next    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next   = ST_START;
                    fifo_pop     = 1'b1;
                    bit_idx_next = '0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_next   = ST_DATA;
                    bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        state_next   = ST_START;
                        fifo_pop     = 1'b1;
                        bit_idx_next = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Line value is chosen from the upcoming state so uart_tx can be a flop.
        case (state_next)
            ST_START:  line_next = 1'b0;
            ST_DATA:   line_next = shreg[bit_idx_next];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_next = ^shreg;
`endif
            default:   line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state   <= state_next;
            bit_idx <= bit_idx_next;
            uart_tx <= line_next;
            if (fifo_pop) shreg <= fifo_head;
            if (state_next != state || bit_done || state == ST_IDLE)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire
